// File: rtl/irq_ctrl_if.sv
// Bus and interrupt signal bundle for irq_ctrl: the core-side bus port plus the
// interrupt request/acknowledge pair and the level sources.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 8
);
  logic [31:0]        data_i;
  logic [31:0]        addr_i;
  logic               we_i;
  logic [31:0]        data_o;
  logic [NUM_SRC-1:0] irq_src_i;
  logic               int_req_o;
  logic [2:0]         int_id_o;
  logic               int_ack_i;

  modport master (
    output data_i, addr_i, we_i, irq_src_i, int_ack_i,
    input  data_o, int_req_o, int_id_o
  );

  modport slave (
    input  data_i, addr_i, we_i, irq_src_i, int_ack_i,
    output data_o, int_req_o, int_id_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority, non-nesting interrupt controller: level sources latch into
// PENDING, the lowest enabled index is requested, and software completes via CLAIM.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input logic      clk,
  input logic      rst,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] inService_q, inService_d;
  logic               ctrlEn_q, ctrlEn_d;
  logic [2:0]         id_q, id_d;

  logic [3:0]         offset;
  logic               wrEnable, wrCtrl, wrClaim;
  logic [NUM_SRC-1:0] candidates, idMask;
  logic [7:0]         idMaskFull;
  logic [2:0]         lowestIdx;
  logic [3:0]         claimCode;
  logic [31:0]        readData;
  logic               unusedBits;

  assign offset     = bus.addr_i[3:0];
  assign wrEnable   = bus.we_i && (offset == 4'h0);
  assign wrCtrl     = bus.we_i && (offset == 4'hC);
  assign wrClaim    = bus.we_i && (offset == 4'h8);
  assign candidates = pending_q & enable_q;
  assign idMaskFull = 8'b1 << id_q;
  assign idMask     = idMaskFull[NUM_SRC-1:0];
  assign claimCode  = {1'b0, id_q} + 4'd1;
  assign unusedBits = ^{bus.addr_i, bus.data_i};

  // Scan downwards so the lowest set index wins.
  always_comb begin
    lowestIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (candidates[i]) lowestIdx = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    pending_d   = pending_q | (bus.irq_src_i & ~inService_q);
    inService_d = inService_q;
    enable_d    = wrEnable ? bus.data_i[NUM_SRC-1:0] : enable_q;
    ctrlEn_d    = wrCtrl ? bus.data_i[0] : ctrlEn_q;

    case (state_q)
      IDLE: begin
        if (ctrlEn_q && (|candidates)) begin
          state_d = REQ;
          id_d    = lowestIdx;
        end
      end
      REQ: begin
        // Acknowledge beats a withdrawn enable; the clear beats a same-cycle re-set.
        if (bus.int_ack_i) begin
          state_d     = SERVICE;
          pending_d   = pending_d & ~idMask;
          inService_d = inService_q | idMask;
        end else if (!ctrlEn_q || !(|(enable_q & idMask))) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (wrClaim && (bus.data_i[3:0] == claimCode)) begin
          state_d     = IDLE;
          inService_d = inService_q & ~idMask;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enable_q    <= '0;
      pending_q   <= '0;
      inService_q <= '0;
      ctrlEn_q    <= 1'b0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inService_q <= inService_d;
      ctrlEn_q    <= ctrlEn_d;
      id_q        <= id_d;
    end
  end

  // Reads are forced to zero during reset so software never sees stale state.
  always_comb begin
    readData = '0;
    if (!rst) begin
      case (offset)
        4'h0: readData[NUM_SRC-1:0] = enable_q;
        4'h4: readData[NUM_SRC-1:0] = pending_q;
        4'h8: if (state_q == SERVICE) readData[3:0] = claimCode;
        4'hC: readData[0] = ctrlEn_q;
        default: readData = '0;
      endcase
    end
  end

  assign bus.data_o    = readData;
  assign bus.int_req_o = !rst && (state_q == REQ);
  assign bus.int_id_o  = rst ? 3'd0 : id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with hand-derived
// expectations, then randomized traffic checked against a rule-level model.
module tb_irq_ctrl;
  localparam int NSRC = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] rd;

  int unsigned mEn, mPend, mIns, mId;
  bit          mCtrl, mReq, mSvc;

  irq_ctrl_if #(.NUM_SRC(NSRC)) bus();
  irq_ctrl #(.NUM_SRC(NSRC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input logic [3:0] off, input logic [31:0] val);
    bus.addr_i = {28'h0, off};
    bus.data_i = val;
    bus.we_i   = 1'b1;
    @(negedge clk);
    bus.we_i   = 1'b0;
    bus.data_i = '0;
  endtask

  task automatic busRead(input logic [3:0] off, output logic [31:0] val);
    bus.we_i   = 1'b0;
    bus.addr_i = {28'h0, off};
    #1;
    val = bus.data_o;
  endtask

  task automatic ackOnce();
    bus.int_ack_i = 1'b1;
    tick(1);
    bus.int_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] offs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    rst = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      busRead(offs[k], rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL rst_read off=%h got %h want 0", offs[k], rd); end
    end
    tests++; if (bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL rst_req got %b want 0", bus.int_req_o); end
    tests++; if (bus.int_id_o !== 3'd0) begin fails++; $display("[TB] FAIL rst_id got %0d want 0", bus.int_id_o); end
    tick(1);
    rst = 1'b0;
    tick(1);
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL post_rst_pending got %h want 0", rd); end
  endtask

  task automatic test_single();
    busWrite(4'h0, 32'h01);
    busWrite(4'hC, 32'h01);
    bus.irq_src_i = 8'h01;
    tick(1);
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h01) begin fails++; $display("[TB] FAIL s1_pending got %h want 01", rd); end
    tests++; if (bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL s1_req_early got %b want 0", bus.int_req_o); end
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1) begin fails++; $display("[TB] FAIL s1_req got %b want 1", bus.int_req_o); end
    tests++; if (bus.int_id_o !== 3'd0) begin fails++; $display("[TB] FAIL s1_id got %0d want 0", bus.int_id_o); end
    ackOnce();
    bus.irq_src_i = 8'h00;
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h1) begin fails++; $display("[TB] FAIL s1_claim got %h want 1", rd); end
    tests++; if (bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL s1_req_svc got %b want 0", bus.int_req_o); end
    busWrite(4'h8, 32'h1);
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL s1_claim_done got %h want 0", rd); end
  endtask

  task automatic test_priority();
    busWrite(4'h0, 32'hFF);
    bus.irq_src_i = 8'h24;
    tick(1);
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h24) begin fails++; $display("[TB] FAIL s2_pending got %h want 24", rd); end
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd2) begin fails++; $display("[TB] FAIL s2_first got req=%b id=%0d want req=1 id=2", bus.int_req_o, bus.int_id_o); end
    bus.irq_src_i = 8'h00;
    ackOnce();
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h3) begin fails++; $display("[TB] FAIL s2_claim2 got %h want 3", rd); end
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h20) begin fails++; $display("[TB] FAIL s2_pending_left got %h want 20", rd); end
    busWrite(4'h8, 32'h3);
    tests++; if (bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL s2_idle got %b want 0", bus.int_req_o); end
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd5) begin fails++; $display("[TB] FAIL s2_second got req=%b id=%0d want req=1 id=5", bus.int_req_o, bus.int_id_o); end
    ackOnce();
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h6) begin fails++; $display("[TB] FAIL s2_claim5 got %h want 6", rd); end
    busWrite(4'h8, 32'h6);
  endtask

  task automatic test_claim_mismatch();
    bus.irq_src_i = 8'h04;
    tick(2);
    busWrite(4'h8, 32'h3);
    tests++; if (bus.int_req_o !== 1'b1) begin fails++; $display("[TB] FAIL s3_claim_in_req got req=%b want 1", bus.int_req_o); end
    ackOnce();
    busWrite(4'h8, 32'h4);
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h3) begin fails++; $display("[TB] FAIL s3_wrong_claim got %h want 3", rd); end
    busWrite(4'h8, 32'h3);
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL s3_claim_ok got %h want 0", rd); end
    tick(1);
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h04 || bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL s3_repend got pend=%h req=%b want 04/0", rd, bus.int_req_o); end
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd2) begin fails++; $display("[TB] FAIL s3_rereq got req=%b id=%0d want 1/2", bus.int_req_o, bus.int_id_o); end
    bus.irq_src_i = 8'h00;
    ackOnce();
    busWrite(4'h8, 32'h3);
  endtask

  task automatic test_ctrl_drop();
    bus.irq_src_i = 8'h02;
    tick(2);
    bus.irq_src_i = 8'h00;
    busWrite(4'hC, 32'h0);
    tick(1);
    busRead(4'h4, rd);
    tests++; if (bus.int_req_o !== 1'b0) begin fails++; $display("[TB] FAIL s4_drop got req=%b want 0", bus.int_req_o); end
    tests++; if (rd !== 32'h02) begin fails++; $display("[TB] FAIL s4_pending got %h want 02", rd); end
    busWrite(4'hC, 32'h1);
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd1) begin fails++; $display("[TB] FAIL s4_reissue got req=%b id=%0d want 1/1", bus.int_req_o, bus.int_id_o); end
  endtask

  task automatic test_ack_priority();
    bus.int_ack_i = 1'b1;
    busWrite(4'hC, 32'h0);
    bus.int_ack_i = 1'b0;
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h2) begin fails++; $display("[TB] FAIL s5_service got claim=%h want 2", rd); end
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL s5_pending got %h want 0", rd); end
    busWrite(4'h8, 32'h2);
    busWrite(4'hC, 32'h1);
  endtask

  task automatic test_back_to_back_reset();
    logic [3:0] offs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    bus.irq_src_i = 8'h08;
    tick(2);
    ackOnce();
    bus.irq_src_i = 8'h00;
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h4) begin fails++; $display("[TB] FAIL s6_service got %h want 4", rd); end
    rst = 1'b1;
    busRead(4'h8, rd);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL s6_claim_in_rst got %h want 0", rd); end
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      busRead(offs[k], rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL s6_after_rst off=%h got %h want 0", offs[k], rd); end
    end
    tests++; if (bus.int_req_o !== 1'b0 || bus.int_id_o !== 3'd0) begin fails++; $display("[TB] FAIL s6_outs got req=%b id=%0d want 0/0", bus.int_req_o, bus.int_id_o); end
    busWrite(4'h0, 32'h10);
    busWrite(4'hC, 32'h1);
    bus.irq_src_i = 8'h10;
    tick(1);
    busRead(4'h4, rd);
    tests++; if (rd !== 32'h10) begin fails++; $display("[TB] FAIL s6_new_pend got %h want 10", rd); end
    tick(1);
    tests++; if (bus.int_req_o !== 1'b1 || bus.int_id_o !== 3'd4) begin fails++; $display("[TB] FAIL s6_new_req got req=%b id=%0d want 1/4", bus.int_req_o, bus.int_id_o); end
    bus.irq_src_i = 8'h00;
    ackOnce();
    busWrite(4'h8, 32'h5);
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    case (a[3:0])
      4'h0: return mEn;
      4'h4: return mPend;
      4'h8: return mSvc ? mId + 1 : 32'h0;
      4'hC: return {31'b0, mCtrl};
      default: return 32'h0;
    endcase
  endfunction

  // One clock of the controller's rules, applied to the inputs present at the edge.
  task automatic modelStep();
    int unsigned nPend, nIns, nId, ready;
    bit nReq, nSvc, found;
    nPend = mPend | ({24'h0, bus.irq_src_i} & ~mIns & 32'hFF);
    nIns = mIns; nId = mId; nReq = mReq; nSvc = mSvc;
    ready = mPend & mEn;
    if (mReq) begin
      if (bus.int_ack_i) begin
        nPend = nPend & ~(32'h1 << mId);
        nIns = mIns | (32'h1 << mId);
        nReq = 0; nSvc = 1;
      end else if (!mCtrl || ((mEn >> mId) & 1) == 0) begin
        nReq = 0;
      end
    end else if (mSvc) begin
      if (bus.we_i && bus.addr_i[3:0] == 4'h8 && bus.data_i[3:0] == 4'(mId + 1)) begin
        nIns = mIns & ~(32'h1 << mId);
        nSvc = 0;
      end
    end else if (mCtrl && ready != 0) begin
      found = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (!found && ((ready >> i) & 1) == 1) begin nId = i; found = 1; end
      end
      nReq = 1;
    end
    if (bus.we_i && bus.addr_i[3:0] == 4'h0) mEn = bus.data_i & 32'hFF;
    if (bus.we_i && bus.addr_i[3:0] == 4'hC) mCtrl = bus.data_i[0];
    mPend = nPend; mIns = nIns; mId = nId; mReq = nReq; mSvc = nSvc;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [7:0]  flip;
    int          pick;
    bus.irq_src_i = 8'h00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    mEn = 0; mPend = 0; mIns = 0; mId = 0; mCtrl = 0; mReq = 0; mSvc = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.irq_src_i = bus.irq_src_i ^ flip;
      bus.int_ack_i = ($urandom_range(0, 2) == 0);
      r = $urandom;
      pick = $urandom_range(0, 9);
      bus.we_i = 1'b1;
      case (pick)
        0: begin bus.addr_i = {r[31:4], 4'h0}; bus.data_i = $urandom; end
        1: begin bus.addr_i = {r[31:4], 4'hC}; bus.data_i = {$urandom_range(0, 7) << 1, 1'b1 ^ ($urandom_range(0, 3) == 0)}; end
        2, 3: begin
          bus.addr_i = {r[31:4], 4'h8};
          bus.data_i = (mSvc && $urandom_range(0, 3) != 0) ? mId + 1 : $urandom;
        end
        4: begin bus.addr_i = {r[31:4], 4'h4}; bus.data_i = $urandom; end
        5: begin bus.addr_i = {r[31:4], 4'h6}; bus.data_i = $urandom; end
        default: begin
          bus.we_i = 1'b0;
          bus.data_i = $urandom;
          bus.addr_i = (pick == 6) ? r : {r[31:4], 2'(pick - 7), 2'b00};
        end
      endcase
      #1;
      tests++; if (bus.data_o !== expRead(bus.addr_i)) begin fails++; $display("[TB] FAIL rnd_read cyc=%0d addr=%h got %h want %h", cyc, bus.addr_i, bus.data_o, expRead(bus.addr_i)); end
      tests++; if (bus.int_req_o !== mReq) begin fails++; $display("[TB] FAIL rnd_req cyc=%0d got %b want %b", cyc, bus.int_req_o, mReq); end
      tests++; if (bus.int_id_o !== 3'(mId)) begin fails++; $display("[TB] FAIL rnd_id cyc=%0d got %0d want %0d", cyc, bus.int_id_o, mId); end
      @(posedge clk);
      modelStep();
      @(negedge clk);
    end
    bus.we_i = 1'b0;
    bus.int_ack_i = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.we_i      = 1'b0;
    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus.int_ack_i = 1'b0;
    bus.irq_src_i = '0;
    test_reset();
    test_single();
    test_priority();
    test_claim_mismatch();
    test_ctrl_drop();
    test_ack_priority();
    test_back_to_back_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, meaning the number of level interrupt sources (1..8); source 0 SHALL be the timer pending bit.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  input  1  sole clock; all state updates on the rising edge.
  rst  input  1  reset; synchronous, active-high.
  data_i  input  32  bus write data.
  addr_i  input  32  bus address; only addr_i[3:0] is decoded.
  we_i  input  1  bus write enable, active-high.
  data_o  output  32  bus read data; combinational from addr_i and state.
  irq_src_i  input  NUM_SRC  level interrupt sources, active-high.
  int_req_o  output  1  interrupt request to the core.
  int_id_o  output  3  index of the requested source.
  int_ack_i  input  1  core acknowledge, sampled while int_req_o=1.

Function
REQ-003 The register map SHALL be: 0x0 ENABLE (RW, bits [NUM_SRC-1:0]); 0x4 PENDING (RO); 0x8 CLAIM (read: {28'b0, id+1} in SERVICE, else 0; write: complete); 0xC CTRL (RW, bit0 = global enable).
REQ-004 Reads of undefined offsets, and all reads while rst=1, SHALL return 0; unused register bits SHALL read 0.
REQ-005 Writes to PENDING and undefined offsets SHALL be ignored.
REQ-006 pending[i] SHALL be set on the clock after irq_src_i[i]=1 while inservice[i]=0, independent of ENABLE.
REQ-007 pending[i] SHALL be cleared only by claim (REQ-010); a set and a clear of the same bit in the same cycle SHALL resolve as clear.
REQ-008 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-009 IDLE -> REQ SHALL occur when CTRL[0]=1 and (pending & ENABLE) is nonzero.
  - On that edge, the lowest-index set bit SHALL be captured into the id register.
  - Fixed priority: index 0 is highest.
REQ-010 In REQ, the block SHALL drive int_req_o=1 and int_id_o=id.
  - int_ack_i=1 SHALL move the FSM to SERVICE, clear pending[id] and set inservice[id].
REQ-011 In REQ, if CTRL[0]=0 or ENABLE[id]=0 and int_ack_i=0, the FSM SHALL return to IDLE.
  - pending SHALL be left unchanged.
  - If int_ack_i=1 in that same cycle, the acknowledge SHALL take priority.
REQ-012 In SERVICE, a write to CLAIM with data_i[3:0]==id+1 SHALL clear inservice[id] and return the FSM to IDLE.
  - Any other CLAIM value, and CLAIM writes in IDLE or REQ, SHALL be ignored.
REQ-013 int_req_o SHALL be 0 in IDLE and SERVICE; int_id_o SHALL equal id in all states.
REQ-014 Latency: a source rising at edge N with the FSM in IDLE, enabled and the highest-priority candidate SHALL give pending at N+1 and int_req_o=1 at N+2.
REQ-015 After completion, a still-high source SHALL re-pend one cycle after inservice clears and SHALL be re-requested two cycles later, with no lost or duplicate claim.
REQ-016 Only one source SHALL be in service at a time; nesting is not supported.

Reset
REQ-017 While rst=1 the following SHALL reset:
  - ENABLE, CTRL, pending, inservice and id SHALL become 0.
  - The FSM SHALL go to IDLE.
  - int_req_o=0, int_id_o=0 and data_o=0.
REQ-018 Reset asserted in REQ or SERVICE SHALL abort immediately, with no completion required afterwards.

Verification
REQ-019 Bench scenario 1: ENABLE=0x01, CTRL=1, irq_src_i[0] rises at edge N -> PENDING=0x01 at N+1; int_req_o=1 and int_id_o=0 at N+2.
REQ-020 Bench scenario 2: sources 5 and 2 rise together, ENABLE=0xFF, CTRL=1.
  - int_id_o=2 is requested first; ack, then CLAIM write 3.
  - int_id_o=5 is then requested; after its ack, CLAIM reads 6.
REQ-021 Bench scenario 3: in SERVICE with id=2, write CLAIM=4 -> state unchanged and CLAIM still reads 3; write CLAIM=3 -> IDLE and inservice cleared.
REQ-022 Bench scenario 4: in REQ, write CTRL=0 with int_ack_i=0 -> int_req_o=0 next cycle, PENDING unchanged; write CTRL=1 -> request reissued.
REQ-023 Bench scenario 5: in REQ, write CTRL=0 and int_ack_i=1 in the same cycle -> SERVICE entered and pending[id] cleared.
REQ-024 Bench scenario 6: assert rst for one cycle while in SERVICE -> all registers read 0, int_req_o=0, and the FSM accepts a new source normally afterwards.
